// File: rtl/lc_port_arbiter.sv
// Shares the single lower-cache port between L1I (requester 0) and L1D (requester 1).
// It uses a round-robin grant, a registered request slot, and in-order routing of read responses by requester ID.
module lc_port_arbiter #(
   parameter int unsigned PADDR_BITS = 22,
   parameter int unsigned LINE_BITS  = 512,
   parameter int unsigned ID_DEPTH   = 4
) (
   input  logic                             clk_in,
   input  logic                             rst_N_in,
   input  logic [1:0]                       req_valid_in,
   output logic [1:0]                       req_ready_out,
   input  logic [1:0][PADDR_BITS-1:0]       req_addr_in,
   input  logic [1:0][LINE_BITS-1:0]        req_value_in,
   input  logic [1:0]                       req_we_in,
   output logic [1:0]                       resp_valid_out,
   input  logic [1:0]                       resp_ready_in,
   output logic [PADDR_BITS-1:0]            resp_addr_out,
   output logic [LINE_BITS-1:0]             resp_value_out,
   output logic                             lc_valid_out,
   input  logic                             lc_ready_in,
   output logic [PADDR_BITS-1:0]            lc_addr_out,
   output logic [LINE_BITS-1:0]             lc_value_out,
   output logic                             lc_we_out,
   input  logic                             lc_resp_valid_in,
   output logic                             lc_resp_ready_out,
   input  logic [PADDR_BITS-1:0]            lc_resp_addr_in,
   input  logic [LINE_BITS-1:0]             lc_resp_value_in,
   output logic                             err_out
);

   localparam int unsigned PW = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;
   localparam int unsigned CW = $clog2(ID_DEPTH + 1);

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [ID_DEPTH-1:0]   ids_q, ids_d;
   logic                  prio_q, prio_d;
   logic                  lc_valid_q, lc_valid_d;
   logic                  lc_we_q, lc_we_d;
   logic [PADDR_BITS-1:0] lc_addr_q, lc_addr_d;
   logic [LINE_BITS-1:0]  lc_value_q, lc_value_d;
   logic                  err_q, err_d;

   logic       empty, full, head, slot_free, grant_vld, gnt, push, pop;
   logic [1:0] elig;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(ID_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Grant and response steering
   always_comb begin
      empty     = (count_q == '0);
      full      = (count_q >= CW'(ID_DEPTH));
      head      = ids_q[rd_ptr_q];
      slot_free = !lc_valid_q || lc_ready_in;
      elig[0]   = req_valid_in[0] && (req_we_in[0] || !full);
      elig[1]   = req_valid_in[1] && (req_we_in[1] || !full);
      grant_vld = slot_free && (elig != 2'b00);
      gnt       = (elig == 2'b11) ? prio_q : elig[1];
      push      = grant_vld && !req_we_in[gnt];
      pop       = lc_resp_valid_in && !empty && resp_ready_in[head];

      req_ready_out     = 2'b00;
      req_ready_out[0]  = rst_N_in && grant_vld && !gnt;
      req_ready_out[1]  = rst_N_in && grant_vld && gnt;
      resp_valid_out    = 2'b00;
      resp_valid_out[0] = lc_resp_valid_in && !empty && !head;
      resp_valid_out[1] = lc_resp_valid_in && !empty && head;
      // An empty FIFO swallows stray response beats so the LC never wedges
      lc_resp_ready_out = empty ? lc_resp_valid_in : resp_ready_in[head];
      resp_addr_out     = lc_resp_addr_in;
      resp_value_out    = lc_resp_value_in;
   end

   always_comb begin
      prio_d     = prio_q;
      lc_valid_d = lc_valid_q;
      lc_we_d    = lc_we_q;
      lc_addr_d  = lc_addr_q;
      lc_value_d = lc_value_q;
      ids_d      = ids_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      err_d      = err_q | (lc_resp_valid_in && empty);

      if (grant_vld) begin
         prio_d     = !gnt;
         lc_valid_d = 1'b1;
         lc_we_d    = req_we_in[gnt];
         lc_addr_d  = req_addr_in[gnt];
         lc_value_d = req_value_in[gnt];
      end else if (slot_free) begin
         lc_valid_d = 1'b0;
      end

      if (push) begin
         ids_d[wr_ptr_q] = gnt;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         prio_q     <= 1'b0;
         lc_valid_q <= 1'b0;
         lc_we_q    <= 1'b0;
         lc_addr_q  <= '0;
         lc_value_q <= '0;
         ids_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         prio_q     <= prio_d;
         lc_valid_q <= lc_valid_d;
         lc_we_q    <= lc_we_d;
         lc_addr_q  <= lc_addr_d;
         lc_value_q <= lc_value_d;
         ids_q      <= ids_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         err_q      <= err_d;
      end
   end

   assign lc_valid_out = lc_valid_q;
   assign lc_we_out    = lc_we_q;
   assign lc_addr_out  = lc_addr_q;
   assign lc_value_out = lc_value_q;
   assign err_out      = err_q;

endmodule

// File: tb/tb_lc_port_arbiter.sv
// Directed and random checks of lc_port_arbiter against a queue-based transaction model.
module tb_lc_port_arbiter;

   localparam int unsigned PA    = 22;
   localparam int unsigned LB    = 512;
   localparam int unsigned DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [1:0]          req_valid, req_ready, req_we, resp_valid, resp_ready;
   logic [1:0][PA-1:0]  req_addr;
   logic [1:0][LB-1:0]  req_value;
   logic [PA-1:0]       resp_addr, lc_addr, lc_resp_addr;
   logic [LB-1:0]       resp_value, lc_value, lc_resp_value;
   logic                lc_valid, lc_ready, lc_we, lc_resp_valid, lc_resp_ready, err;

   always #5 clk = ~clk;

   lc_port_arbiter #(.PADDR_BITS(PA), .LINE_BITS(LB), .ID_DEPTH(DEPTH)) dut (
      .clk_in(clk), .rst_N_in(rst_n),
      .req_valid_in(req_valid), .req_ready_out(req_ready), .req_addr_in(req_addr),
      .req_value_in(req_value), .req_we_in(req_we),
      .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
      .resp_addr_out(resp_addr), .resp_value_out(resp_value),
      .lc_valid_out(lc_valid), .lc_ready_in(lc_ready), .lc_addr_out(lc_addr),
      .lc_value_out(lc_value), .lc_we_out(lc_we),
      .lc_resp_valid_in(lc_resp_valid), .lc_resp_ready_out(lc_resp_ready),
      .lc_resp_addr_in(lc_resp_addr), .lc_resp_value_in(lc_resp_value),
      .err_out(err)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: outstanding read owners in order, plus the visible request slot
   int             idq[$];
   bit             m_prio, m_lv, m_we, m_err;
   logic [PA-1:0]  m_addr;
   logic [LB-1:0]  m_val;
   logic [1:0]     s_rr, s_rv;
   logic           s_lrr;

   task automatic chk(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [LB-1:0] rand_line();
      logic [LB-1:0] v;
      for (int i = 0; i < LB / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic model_reset();
      idq.delete();
      m_prio = 0; m_lv = 0; m_we = 0; m_err = 0; m_addr = '0; m_val = '0;
   endtask

   task automatic model_comb(output int g, output logic [1:0] rr, output logic [1:0] rv,
                             output logic lrr);
      bit free, full, e0, e1;
      free = !m_lv || lc_ready;
      full = idq.size() >= DEPTH;
      e0 = req_valid[0] && (req_we[0] || !full);
      e1 = req_valid[1] && (req_we[1] || !full);
      g = -1;
      if (free && e0 && e1) g = m_prio ? 1 : 0;
      else if (free && e0) g = 0;
      else if (free && e1) g = 1;
      rr = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      if (idq.size() == 0) begin
         rv = 2'b00;
         lrr = lc_resp_valid;
      end else begin
         rv = !lc_resp_valid ? 2'b00 : (idq[0] == 0) ? 2'b01 : 2'b10;
         lrr = resp_ready[idq[0]];
      end
   endtask

   task automatic cycle();
      int g;
      logic [1:0] rr, rv;
      logic lrr;
      @(negedge clk);
      model_comb(g, rr, rv, lrr);
      s_rr = req_ready; s_rv = resp_valid; s_lrr = lc_resp_ready;
      chk("req_ready", s_rr, rr);
      chk("resp_valid", s_rv, rv);
      chk("lc_resp_ready", s_lrr, lrr);
      chk("resp_addr", resp_addr, lc_resp_addr);
      chk("resp_value", resp_value, lc_resp_value);
      @(posedge clk);
      if (idq.size() == 0) begin
         if (lc_resp_valid) m_err = 1;
      end else if (lc_resp_valid && resp_ready[idq[0]]) begin
         void'(idq.pop_front());
      end
      if (g >= 0) begin
         m_prio = (g == 0);
         m_lv = 1; m_we = req_we[g]; m_addr = req_addr[g]; m_val = req_value[g];
         if (!req_we[g]) idq.push_back(g);
      end else if (!m_lv || lc_ready) begin
         m_lv = 0;
      end
      #1;
      chk("lc_valid", lc_valid, m_lv);
      chk("lc_we", lc_we, m_we);
      chk("lc_addr", lc_addr, m_addr);
      chk("lc_value", lc_value, m_val);
      chk("err", err, m_err);
   endtask

   task automatic idle();
      req_valid = 0; req_we = 0; req_addr = '0; req_value = '0;
      lc_ready = 1; resp_ready = 2'b11;
      lc_resp_valid = 0; lc_resp_addr = '0; lc_resp_value = '0;
   endtask

   // Reset lands mid-cycle so its asynchronous effect is observed before any edge
   task automatic do_reset();
      rst_n = 0;
      #1;
      model_reset();
      chk("rst_lc_valid", lc_valid, 0);
      chk("rst_lc_we", lc_we, 0);
      chk("rst_lc_addr", lc_addr, 0);
      chk("rst_lc_value", lc_value, 0);
      chk("rst_err", err, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      @(posedge clk);
      #2 rst_n = 1;
   endtask

   initial begin
      rst_n = 1;
      idle();
      req_valid = 2'b11;
      #2 do_reset();
      idle();

      // Single read and its response
      req_valid = 2'b01; req_addr[0] = PA'(32'h1000);
      cycle();
      chk("t1_grant", s_rr, 2'b01);
      chk("t1_lc_addr", lc_addr, PA'(32'h1000));
      chk("t1_lc_we", lc_we, 0);
      req_valid = 0; lc_resp_valid = 1; lc_resp_value = LB'(32'hDEADBEEF);
      cycle();
      chk("t1_resp_valid", s_rv, 2'b01);
      lc_resp_valid = 0;
      cycle();

      // Round robin, then a lone requester
      do_reset(); idle();
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t2_rr_alt", s_rr, (i % 2) ? 2'b10 : 2'b01);
      end
      do_reset(); idle();
      req_valid = 2'b10;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t2_rr_r1", s_rr, 2'b10);
      end

      // LC stall holds the slot
      do_reset(); idle();
      req_valid = 2'b10; req_we = 2'b10; req_addr[1] = PA'(32'h2000); req_value[1] = LB'(16'hC0C0);
      cycle();
      req_valid = 2'b01; req_we = 2'b00; req_addr[0] = PA'(32'h0444); lc_ready = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t3_stall_rr", s_rr, 2'b00);
         chk("t3_stall_addr", lc_addr, PA'(32'h2000));
         chk("t3_stall_value", lc_value, LB'(16'hC0C0));
         chk("t3_stall_we", lc_we, 1);
      end
      lc_ready = 1;
      cycle();
      chk("t3_release_rr", s_rr, 2'b01);

      // Full ID FIFO blocks reads but not writes
      do_reset(); idle();
      req_valid = 2'b01;
      for (int i = 0; i < 4; i++) begin
         req_addr[0] = PA'(32'h100 + i);
         cycle();
         chk("t4_fill_rr", s_rr, 2'b01);
      end
      req_valid = 2'b11; req_we = 2'b10; req_addr[1] = PA'(32'h3000);
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("t4_full_rr", s_rr, 2'b10);
      end
      chk("t4_lc_addr", lc_addr, PA'(32'h3000));
      req_valid = 0; lc_resp_valid = 1; resp_ready = 2'b01;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t4_drain_rv", s_rv, 2'b01);
      end
      lc_resp_valid = 0;
      cycle();

      // In-order response routing with backpressure
      do_reset(); idle();
      req_valid = 2'b01; req_addr[0] = PA'(32'hA00);
      cycle();
      req_valid = 2'b10; req_addr[1] = PA'(32'hB00);
      cycle();
      req_valid = 0; lc_resp_valid = 1; lc_resp_addr = PA'(32'hA00); resp_ready = 2'b10;
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("t5_bp_lrr", s_lrr, 0);
         chk("t5_bp_rv", s_rv, 2'b01);
      end
      resp_ready = 2'b11;
      cycle();
      chk("t5_a_rv", s_rv, 2'b01);
      chk("t5_a_lrr", s_lrr, 1);
      lc_resp_addr = PA'(32'hB00);
      cycle();
      chk("t5_b_rv", s_rv, 2'b10);
      lc_resp_valid = 0;
      cycle();

      // Spurious response with empty FIFO
      do_reset(); idle();
      lc_resp_valid = 1;
      cycle();
      chk("t6_rv", s_rv, 2'b00);
      chk("t6_lrr", s_lrr, 1);
      chk("t6_err", err, 1);
      lc_resp_valid = 0;
      cycle(); cycle();
      chk("t6_err_sticky", err, 1);
      do_reset(); idle();

      // Random traffic, with occasional resets
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         req_valid     = 2'($urandom);
         req_we[0]     = ($urandom_range(0, 2) == 0);
         req_we[1]     = ($urandom_range(0, 2) == 0);
         req_addr[0]   = PA'($urandom);
         req_addr[1]   = PA'($urandom);
         req_value[0]  = rand_line();
         req_value[1]  = rand_line();
         lc_ready      = ($urandom_range(0, 3) != 0);
         resp_ready    = 2'($urandom);
         lc_resp_valid = (idq.size() > 0) ? 1'($urandom) : ($urandom_range(0, 199) == 0);
         lc_resp_addr  = PA'($urandom);
         lc_resp_value = rand_line();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
